// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller: segment patterns
// (A..G, active-low), scan FSM states and the BCD decode helper.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DIG0 = 7'b0000001;
    localparam logic [6:0] SEG_DIG1 = 7'b1001111;
    localparam logic [6:0] SEG_DIG2 = 7'b0010010;
    localparam logic [6:0] SEG_DIG3 = 7'b0000110;
    localparam logic [6:0] SEG_DIG4 = 7'b1001100;
    localparam logic [6:0] SEG_DIG5 = 7'b0100100;
    localparam logic [6:0] SEG_DIG6 = 7'b0100000;
    localparam logic [6:0] SEG_DIG7 = 7'b0001111;
    localparam logic [6:0] SEG_DIG8 = 7'b0000000;
    localparam logic [6:0] SEG_DIG9 = 7'b0000100;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } seg7_scan_state_t;

    // Non-BCD nibbles map to a dark digit rather than a garbage pattern
    function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_DIG0;
            4'd1:    seg = SEG_DIG1;
            4'd2:    seg = SEG_DIG2;
            4'd3:    seg = SEG_DIG3;
            4'd4:    seg = SEG_DIG4;
            4'd5:    seg = SEG_DIG5;
            4'd6:    seg = SEG_DIG6;
            4'd7:    seg = SEG_DIG7;
            4'd8:    seg = SEG_DIG8;
            4'd9:    seg = SEG_DIG9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder shared across all scanned digits.
module bcd_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg7_decode(bcd_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-boundary shadow update.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN for leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_digits,
    output logic                    upd_ready,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int TMR_MAX    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    localparam logic [TMR_W-1:0] DWELL_END = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [TMR_W-1:0] BLANK_END = TMR_W'(BLANK_LAST);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    seg7_scan_state_t        state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_next_s;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic                    ready_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d, dec_seg_s;
    logic                    frame_q;
    logic [3:0]              nibble_s;
    logic                    lzb_blank_s;

    assign nibble_s = shadow_q[{idx_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd_i (nibble_s),
        .seg_o (dec_seg_s)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_s;

    // lz_s[i] is set when nibble i and every nibble above it are zero
    always_comb begin
        lz_s = {NUM_DIGITS{1'b0}};
        lz_s[NUM_DIGITS-1] = (shadow_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz_s[i] = (shadow_q[4*i +: 4] == 4'h0) && lz_s[i+1];
        end
        lzb_blank_s = (idx_q != {IDX_W{1'b0}}) && lz_s[idx_q];
    end
`else
    assign lzb_blank_s = 1'b0;
`endif

    // Scan sequencing: dwell on a digit, optional guard, then advance with wraparound
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q + TMR_W'(1);
        idx_next_s = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + IDX_W'(1);
        case (state_q)
            ST_ON: begin
                if (timer_q == DWELL_END) begin
                    timer_d = {TMR_W{1'b0}};
                    if (BLANK_CYCLES == 0) begin
                        idx_d = idx_next_s;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_BLANK: begin
                if (timer_q == BLANK_END) begin
                    timer_d = {TMR_W{1'b0}};
                    state_d = ST_ON;
                    idx_d   = idx_next_s;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_ON;
                idx_d   = {IDX_W{1'b0}};
                timer_d = {TMR_W{1'b0}};
            end
        endcase
        // Ready is registered from next state so it lines up with the FSM window itself
        ready_d = (idx_d == IDX_LAST) &&
                  ((state_d == ST_BLANK) ||
                   ((BLANK_CYCLES == 0) && (state_d == ST_ON) && (timer_d == DWELL_END)));
    end

    // Output pattern for the digit currently selected by the FSM
    always_comb begin
        if (state_q == ST_ON) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = lzb_blank_s ? SEG_OFF : dec_seg_s;
        end else begin
            an_d  = {NUM_DIGITS{1'b1}};
            seg_d = SEG_OFF;
        end
    end

    // FSM, shadow digits and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ON;
            idx_q     <= {IDX_W{1'b0}};
            timer_q   <= {TMR_W{1'b0}};
            shadow_q  <= {(4*NUM_DIGITS){1'b1}};
            upd_ready <= 1'b0;
            an_q      <= {NUM_DIGITS{1'b1}};
            seg_q     <= SEG_OFF;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            upd_ready <= ready_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            frame_q   <= (state_q == ST_ON) && (idx_q == {IDX_W{1'b0}}) &&
                         (timer_q == {TMR_W{1'b0}});
            if (upd_valid && upd_ready) begin
                shadow_q <= upd_digits;
            end else begin
                shadow_q <= shadow_q;
            end
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign frame_start = frame_q;

endmodule
